store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side counterpart of the writeback/load path in the RV32 pipeline.
- Accepts store requests from the memory stage, formats them, and buffers them in a small FIFO. Formatting covers byte-lane replication, write mask generation, word-aligned address and misalignment check.
- Issues buffered stores to the data cache over a valid/ready request port.
- Stalls the pipeline when the buffer is full.

Parameters:
- DEPTH, 2, number of store buffer entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- st_valid  in  1  store request from the memory stage this cycle
- st_addr  in  32  byte address of the store (ALU result)
- st_data  in  32  rs2 value, with the store data in the low bits
- st_funct3  in  3  000 SB, 001 SH, 010 SW
- st_stall  out  1  request not accepted; the pipeline holds
- misalign_err  out  1  one-cycle pulse: a store was dropped as misaligned or illegal
- mem_req_valid  out  1  head entry is presented to the dcache
- mem_req_ready  in  1  dcache accepts the head entry
- mem_addr  out  32  {head_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-formatted store data
- mem_wmask  out  4  byte write enables
- count  out  CNT_W  buffer occupancy
- empty  out  1  count == 0; used by fences and load ordering

Behaviour:
- Reset values: all outputs 0, except empty = 1. Pointers and count are cleared. Reset mid-operation discards every buffered store without issuing it.
- Formatting, done combinationally at enqueue time:
  - SB: wmask = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: addr[1]=0 gives 0011, addr[1]=1 gives 1100; wdata = {2{data[15:0]}}; addr[0]=1 is misaligned.
  - SW: wmask = 1111; wdata = data; addr[1:0] != 0 is misaligned.
  - funct3 outside {000, 001, 010} is illegal.
- Accept rule: a request is accepted when st_valid & !full.
  - st_stall = st_valid & full, combinational.
  - Full is evaluated on the registered count. A dequeue in the same cycle does not free a slot for that request.
- Dropped requests: a misaligned or illegal request is accepted (no stall), not enqueued, and misalign_err pulses in the following cycle. If the buffer is full, the request is stalled first, then checked once accepted.
- Enqueue latency: an entry accepted in cycle N reaches the dcache port no earlier than cycle N+1. mem_req_valid = !empty.
- Handshake: dequeue on mem_req_valid & mem_req_ready.
  - While valid and not ready, mem_addr, mem_wdata and mem_wmask hold stable.
  - mem_req_valid never deasserts without a dequeue, except on reset.
- Ordering: strict FIFO. Stores reach the dcache in program order.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full is count == DEPTH.

Optional Feature:
- Macro: STORE_FWD_EN.
- When defined, the block adds these ports:
  - ld_addr  in  32
  - fwd_hit  out  1
  - fwd_data  out  32
  - fwd_mask  out  4
- Forwarding, all combinational:
  - For each byte lane, take the youngest buffered entry whose word address matches ld_addr[31:2] and whose mask bit is set.
  - fwd_mask is the OR of those lanes; fwd_data carries those bytes; fwd_hit = |fwd_mask.
  - The writeback load path merges fwd_data over the dcache output wherever fwd_mask is set.
- When not defined, these ports are absent. Loads must wait for empty before reading the dcache (enforced by hazard logic outside this block).

Decomposition:
- Shared package rv_mem_pkg holds:
  - funct3 store constants FN3_SB, FN3_SH, FN3_SW;
  - the store entry struct {addr[31:2], wdata, wmask};
  - a function store_format(addr, data, funct3) returning entry plus misaligned flag.
- One natural sub-module: store_fifo, a generic DEPTH-entry sync FIFO with count, full and empty. The forwarding scan sits in the top level and reads the FIFO storage through an exposed array port under STORE_FWD_EN.

Test Plan:
- SB, addr 0x1003, data 0x000000AB, ready=1 → next cycle: mem_addr 0x1000, wmask 1000, wdata 0xABABABAB; the cycle after, empty=1.
- SH to 0x2002 with data 0x1234, then SW to 0x2004 with data 0xDEADBEEF, ready held 0 → count=2, st_stall=1 on a third store. Raise ready → stores issue in order: wmask 1100 / wdata 0x12341234, then 1111 / 0xDEADBEEF; the third store is then accepted.
- SW to 0x3001 → no enqueue, count stays 0, misalign_err=1 for exactly one cycle. Repeat with funct3=011 → same result.
- Fill to DEPTH with ready=0, then assert reset for one cycle → count=0, empty=1, mem_req_valid=0, and nothing is issued afterwards.
- Full buffer, ready=1, and st_valid asserted in the same cycle → st_stall=1 that cycle. Next cycle the store is accepted; count ends at DEPTH.
- (STORE_FWD_EN) Buffer SW 0x11223344 @0x40, then SB 0xAA @0x41; ld_addr=0x40 → fwd_hit=1, fwd_mask=1111, fwd_data=0x1122AA44.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared RV32 memory-side types: store funct3 codes, the buffered store entry and the
// enqueue-time formatter (lane replication, byte mask, word address, misalignment).
package rv_mem_pkg;

  localparam logic [2:0] FN3_SB = 3'b000;
  localparam logic [2:0] FN3_SH = 3'b001;
  localparam logic [2:0] FN3_SW = 3'b010;

  typedef struct packed {
    logic [29:0] addr;   // word address, addr[31:2]
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } store_entry_t;

  localparam int STORE_ENTRY_W = $bits(store_entry_t);

  typedef struct packed {
    store_entry_t entry;
    logic         misaligned;
  } store_fmt_t;

  // misaligned also covers illegal funct3: either way the store is dropped.
  function automatic store_fmt_t store_format(input logic [31:0] addr,
                                              input logic [31:0] data,
                                              input logic [2:0]  funct3);
    store_fmt_t r;
    r.entry.addr  = addr[31:2];
    r.entry.wdata = data;
    r.entry.wmask = 4'b0000;
    r.misaligned  = 1'b0;
    case (funct3)
      FN3_SB: begin
        r.entry.wmask = 4'b0001 << addr[1:0];
        r.entry.wdata = {4{data[7:0]}};
      end
      FN3_SH: begin
        r.entry.wmask = addr[1] ? 4'b1100 : 4'b0011;
        r.entry.wdata = {2{data[15:0]}};
        r.misaligned  = addr[0];
      end
      FN3_SW: begin
        r.entry.wmask = 4'b1111;
        r.misaligned  = |addr[1:0];
      end
      default: r.misaligned = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic DEPTH-entry synchronous FIFO with occupancy count; head visible combinationally.
// Push is ignored when full and pop when empty; pointers wrap modulo DEPTH (power of two).
module store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
`ifdef STORE_FWD_EN
  output logic [WIDTH-1:0] mem_o [DEPTH],
  output logic [PTR_W-1:0] rd_ptr_o,
`endif
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
`ifdef STORE_FWD_EN
  assign mem_o      = mem_q;
  assign rd_ptr_o   = rd_ptr_q;
`endif

endmodule

// File: rtl/store_unit.sv
// RV32 store buffer: formats stores, queues them in order, issues to dcache over valid/ready.
// Enqueue-to-issue >= 1 cycle; stalls requester while full. STORE_FWD_EN adds store-to-load forwarding.
module store_unit
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [2:0]       st_funct3,
  output logic             st_stall,
  output logic             misalign_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  output logic [CNT_W-1:0] count,
`ifdef STORE_FWD_EN
  input  logic [31:0]      ld_addr,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data,
  output logic [3:0]       fwd_mask,
`endif
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  store_fmt_t   fmt;
  store_entry_t head;
  logic         full, accept, push, pop;
  logic         misalign_q, misalign_d;

  assign fmt    = store_format(st_addr, st_data, st_funct3);
  // Full comes from the registered count, so a same-cycle dequeue never frees a slot.
  assign accept = st_valid & ~full;
  assign push   = accept & ~fmt.misaligned;
  assign pop    = mem_req_valid & mem_req_ready;

  assign st_stall   = st_valid & full;
  assign misalign_d = accept & fmt.misaligned;

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
  assign misalign_err = misalign_q;

`ifdef STORE_FWD_EN
  logic [STORE_ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]         fifo_rd_ptr;
`endif

  store_fifo #(
    .WIDTH (STORE_ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (fmt.entry),
    .pop_i      (pop),
    .head_dat_o (head),
    .count_o    (count),
    .full_o     (full),
`ifdef STORE_FWD_EN
    .mem_o      (fifo_mem),
    .rd_ptr_o   (fifo_rd_ptr),
`endif
    .empty_o    (empty)
  );

  // Stale storage is masked so the request port reads zero whenever nothing is pending.
  assign mem_req_valid = ~empty;
  assign mem_addr      = empty ? 32'h0 : {head.addr, 2'b00};
  assign mem_wdata     = empty ? 32'h0 : head.wdata;
  assign mem_wmask     = empty ? 4'h0  : head.wmask;

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] scan_idx;
  store_entry_t     scan_e;

  // Walk oldest to youngest so a younger matching lane overwrites an older one.
  always_comb begin
    fwd_data = 32'h0;
    fwd_mask = 4'h0;
    scan_idx = '0;
    scan_e   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = fifo_rd_ptr + PTR_W'(i);
      scan_e   = fifo_mem[scan_idx];
      if ((CNT_W'(i) < count) && (scan_e.addr == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (scan_e.wmask[b]) begin
            fwd_mask[b]        = 1'b1;
            fwd_data[8*b +: 8] = scan_e.wdata[8*b +: 8];
          end
        end
      end
    end
  end
  assign fwd_hit = |fwd_mask;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected dcache requests are queued at acceptance
// and compared in order as the DUT issues them.
module tb_store_unit;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic [31:0]      st_addr, st_data;
  logic [2:0]       st_funct3;
  logic             st_stall, misalign_err, mem_req_valid, mem_req_ready;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_wmask;
  logic [CNT_W-1:0] count;
  logic             empty;
`ifdef STORE_FWD_EN
  logic [31:0]      ld_addr;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [3:0]       fwd_mask;
`endif

  always #5 clk = ~clk;

  store_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_funct3     (st_funct3),
    .st_stall      (st_stall),
    .misalign_err  (misalign_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .count         (count),
`ifdef STORE_FWD_EN
    .ld_addr       (ld_addr),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
    .fwd_mask      (fwd_mask),
`endif
    .empty         (empty)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_issued = 0;
  logic [67:0] exp_q [$];

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: lane-by-lane view of the store ({addr, wdata, wmask}).
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                       output logic bad, output logic [67:0] exp);
    int          nbytes;
    logic [3:0]  m;
    logic [31:0] w;
    m = 4'h0;
    w = 32'h0;
    if (f3 > 3'd2) begin
      bad = 1'b1;
    end else begin
      nbytes = 1 << f3;
      bad    = (a % nbytes) != 0;
      m      = 4'((1 << nbytes) - 1) << a[1:0];
      for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % nbytes) +: 8];
    end
    exp = {a[31:2], 2'b00, w, m};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; returns one cycle after the accepting edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    logic        acc, bad;
    logic [67:0] e;
    acc = 1'b0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (!st_stall) begin
        acc = 1'b1;
        model(a, d, f3, bad, e);
        if (!bad) exp_q.push_back(e);
      end
      tick();
    end
    st_valid = 1'b0;
    check("store_accepted", acc, 1'b1);
  endtask

  task automatic wait_empty();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (empty) done = 1'b1;
      else tick();
    end
    check("drain_done", done, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Issue monitor with request-hold checking while ready is low.
  bit          held;
  bit [67:0]   held_v;
  logic [67:0] got_e;
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      got_e = {mem_addr, mem_wdata, mem_wmask};
      if (held) begin
        check("hold_valid", mem_req_valid, 1'b1);
        if (mem_req_valid) check("hold_stable", got_e, held_v);
      end
      if (mem_req_valid && mem_req_ready) begin
        check("issue_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          check("issue_order", got_e, exp_q.pop_front());
          n_issued++;
        end
      end
      held   = mem_req_valid && !mem_req_ready;
      held_v = got_e;
    end
  end

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    mem_req_ready = 1'b0;
`ifdef STORE_FWD_EN
    ld_addr = '0;
`endif
    tick(); tick();
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_valid", mem_req_valid, 1'b0);
    check("rst_err", misalign_err, 1'b0);
    check("rst_stall", st_stall, 1'b0);
    check("rst_req_bus", {mem_addr, mem_wdata, mem_wmask}, 68'h0);
    tick();
    reset = 1'b0;
    tick();

    // SB to a high byte lane, dcache ready
    mem_req_ready = 1'b1;
    do_store(32'h0000_1003, 32'h0000_00AB, 3'b000);
    @(negedge clk);
    check("sb_valid_next", mem_req_valid, 1'b1);
    check("sb_fields", {mem_addr, mem_wdata, mem_wmask}, {32'h1000, 32'hABAB_ABAB, 4'b1000});
    tick();
    @(negedge clk);
    check("sb_empty_after", empty, 1'b1);
    tick();

    // SH + SW held off, third store stalls until space frees
    mem_req_ready = 1'b0;
    do_store(32'h0000_2002, 32'h0000_1234, 3'b001);
    do_store(32'h0000_2004, 32'hDEAD_BEEF, 3'b010);
    st_valid = 1'b1; st_addr = 32'h2008; st_data = 32'h0BAD_F00D; st_funct3 = 3'b010;
    @(negedge clk);
    check("full_count", count, DEPTH);
    check("full_stall", st_stall, 1'b1);
    tick();
    mem_req_ready = 1'b1;
    do_store(32'h0000_2008, 32'h0BAD_F00D, 3'b010);
    wait_empty();
    tick();

    // Misaligned / illegal stores are dropped with a single-cycle error pulse
    for (int t = 0; t < 3; t++) begin
      logic [31:0] a;
      logic [2:0]  f;
      a = (t == 1) ? 32'h3000 : 32'h3001;
      f = (t == 0) ? 3'b010 : (t == 1) ? 3'b011 : 3'b001;
      do_store(a, 32'h5555_5555, f);
      @(negedge clk);
      check("drop_err_pulse", misalign_err, 1'b1);
      check("drop_no_enqueue", count, 0);
      tick();
      @(negedge clk);
      check("drop_err_clear", misalign_err, 1'b0);
      check("drop_still_empty", empty, 1'b1);
      tick();
    end

    // Reset mid-operation discards buffered stores
    mem_req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_store(32'h4000 + 4 * i, 32'h4444_0000 + i, 3'b010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1'b1);
    check("midrst_valid", mem_req_valid, 1'b0);
    tick();
    mem_req_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    check("midrst_no_issue", mem_req_valid, 1'b0);
    tick();

    // Full buffer with a same-cycle dequeue still stalls the incoming store
    mem_req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_store(32'h5000 + 4 * i, 32'h5A5A_0000 + i, 3'b010);
    st_valid = 1'b1; st_addr = 32'h5100; st_data = 32'hC0DE_0001; st_funct3 = 3'b010;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("deq_same_cycle_stall", st_stall, 1'b1);
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("accept_after_deq", st_stall, 1'b0);
    begin
      logic        bad;
      logic [67:0] e;
      model(32'h5100, 32'hC0DE_0001, 3'b010, bad, e);
      if (!bad) exp_q.push_back(e);
    end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    check("refill_count", count, DEPTH);
    tick();
    mem_req_ready = 1'b1;
    wait_empty();
    tick();

`ifdef STORE_FWD_EN
    mem_req_ready = 1'b0;
    do_store(32'h0000_0040, 32'h1122_3344, 3'b010);
    do_store(32'h0000_0041, 32'h0000_00AA, 3'b000);
    ld_addr = 32'h40;
    @(negedge clk);
    check("fwd_hit", fwd_hit, 1'b1);
    check("fwd_mask", fwd_mask, 4'b1111);
    check("fwd_data", fwd_data, 32'h1122_AA44);
    tick();
    ld_addr = 32'h44;
    @(negedge clk);
    check("fwd_miss", {fwd_hit, fwd_mask}, 5'b0);
    tick();
    mem_req_ready = 1'b1;
    wait_empty();
    tick();
`endif

    check("issued_total", n_issued > 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
